// File: rtl/ifetch_buffer.sv
// Fetch stage: issues word fetches for pc_in and queues returned instructions with their PC.
// Define IFETCH_MISALIGN_CHECK_EN to turn misaligned PCs into fault entries instead of fetches.
module ifetch_buffer #(
  parameter int unsigned DEPTH       = 2,
  parameter logic [31:0] FAULT_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);
  // state    | meaning
  // ST_RUN   | normal issue and enqueue of responses
  // ST_DRAIN | dropping responses of requests granted before a flush

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW:0]   OCC_MAX = (CW+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;
  state_t state, state_nx;

  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];
  logic [DEPTH-1:0] fifo_fault;
  logic [31:0]      tag_pc     [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [CW-1:0]    count, inflight, discard, discard_nx;
  logic [CW:0]      occupancy;
  logic             issue_ok, misalign, grant, fault_enq;
  logic             rsp_drop, rsp_enq, enq, deq;
  logic [31:0]      enq_instr, enq_pc;
  logic             enq_fault;

  always_comb begin
    occupancy  = {1'b0, count} + {1'b0, inflight};
    issue_ok   = !reset && (state == ST_RUN) && !flush && (occupancy < OCC_MAX);
`ifdef IFETCH_MISALIGN_CHECK_EN
    misalign   = (pc_in[1:0] != 2'b00);
`else
    misalign   = 1'b0;
`endif
    imem_req   = issue_ok && !misalign;
    imem_addr  = {pc_in[31:2], 2'b00};
    grant      = imem_req && imem_gnt;
    // a fault entry bypasses memory, so it must wait behind any outstanding fetch
    fault_enq  = issue_ok && misalign && (inflight == '0);
    pc_advance = grant || fault_enq;

    rsp_drop   = imem_rvalid && (discard != '0);
    rsp_enq    = imem_rvalid && (discard == '0) && (inflight != '0);
    enq        = (rsp_enq || fault_enq) && !flush;
    instr_valid = (count != '0);
    deq        = instr_valid && instr_ready;

    enq_instr  = fault_enq ? FAULT_INSTR : imem_rdata;
    enq_pc     = fault_enq ? pc_in : tag_pc[tag_rd];
    enq_fault  = fault_enq;

    instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
    instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;
    instr_fault = instr_valid && fifo_fault[rd_ptr];

    discard_nx = discard;
    if (rsp_drop)
      discard_nx = discard - C_ONE;
    // a response arriving with the flush is consumed, so it is not counted again
    if (flush && (state == ST_RUN))
      discard_nx = inflight - (rsp_enq ? C_ONE : '0);
    state_nx = (discard_nx != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      inflight <= '0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
        inflight <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + P_ONE;
        if (deq) rd_ptr <= rd_ptr + P_ONE;
        if (enq && !deq)
          count <= count + C_ONE;
        else if (deq && !enq)
          count <= count - C_ONE;
        if (grant)   tag_wr <= tag_wr + P_ONE;
        if (rsp_enq) tag_rd <= tag_rd + P_ONE;
        if (grant && !rsp_enq)
          inflight <= inflight + C_ONE;
        else if (rsp_enq && !grant)
          inflight <= inflight - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_instr[wr_ptr] <= enq_instr;
      fifo_pc[wr_ptr]    <= enq_pc;
      fifo_fault[wr_ptr] <= enq_fault;
    end
    if (grant)
      tag_pc[tag_wr] <= pc_in;
  end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Fetch stage directly downstream of the program counter register.
- Takes the registered PC, issues word fetches to instruction memory over a req/gnt + rvalid protocol, and queues returned instructions with their PC in a DEPTH-entry FIFO for decode.
- Generates pc_advance to tell the PC register when to load next_pc, and handles redirect flushes, including discarding in-flight responses.

Parameters:
- DEPTH, 2, FIFO entries and maximum fetches in flight; power of 2, >=2
- FAULT_INSTR, 32'h00000013, instruction word substituted for a misaligned fetch (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc_in  in  32  current PC from the PC register
- flush  in  1  redirect; pc_in takes the new target next cycle
- pc_advance  out  1  PC register loads next_pc this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  {pc_in[31:2],2'b00}
- imem_gnt  in  1  request accepted when imem_req&&imem_gnt
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response word
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction; 0 when instr_valid=0
- instr_pc  out  32  head PC; 0 when instr_valid=0
- instr_fault  out  1  head is a misaligned-fetch entry; 0 when instr_valid=0

Behaviour:
- Reset: state RUN, FIFO empty, inflight=0, discard=0; all outputs 0. Reset mid-operation drops everything. Responses arriving after reset with inflight=0 are ignored.
- FIFO count is count; slots are reserved at grant.
- Issue condition: state==RUN && !flush && (count+inflight)<DEPTH, evaluated on current-cycle registered values. A same-cycle dequeue does not free a slot until the next cycle.
- imem_req=issue condition. imem_addr follows pc_in combinationally; pc_in is stable until pc_advance.
- pc_advance=imem_req&&imem_gnt (1-cycle pulse). Also asserted for a fault entry (see Optional Feature).
- On grant: inflight+1. The PC of the granted request is pushed into an internal DEPTH-entry pc tag queue.
- Responses: exactly one imem_rvalid per grant, in order, at least 1 cycle after grant.
  - With discard>0: discard-1, drop the word.
  - Otherwise: enqueue {imem_rdata, tag PC, fault=0}, inflight-1.
  - Grant and response in the same cycle: inflight unchanged.
- Dequeue: instr_valid&&instr_ready pops the head. An empty FIFO never pops. Pointers wrap modulo DEPTH. No overflow is possible by reservation.
- Simultaneous enqueue+dequeue: count unchanged, both take effect.
- flush (highest priority, same cycle):
  - FIFO cleared.
  - imem_req=0, pc_advance=0. The memory tolerates request withdrawal on flush.
  - discard <= inflight minus any response consumed that cycle; inflight<=0; tag queue cleared.
  - If the new discard>0, state goes to DRAIN, else stays RUN.
- DRAIN: no requests. Each rvalid decrements discard. At discard reaching 0, state goes to RUN and issue may resume the next cycle.
- flush while in DRAIN: FIFO stays empty, discard is unchanged.
- Latency: grant at cycle N, rvalid at N+k gives instr_valid at N+k+1.

Optional Feature:
- Macro IFETCH_MISALIGN_CHECK_EN.
- Defined: when pc_in[1:0]!=0 and the issue condition holds (with a free FIFO slot):
  - No memory request is made; imem_req=0.
  - pc_advance=1.
  - Entry {FAULT_INSTR, pc_in, fault=1} is enqueued directly, but only after inflight==0, to preserve order. While inflight>0, wait.
- Not defined: pc_in[1:0] is ignored, the fetch is word-aligned, and instr_fault is tied 0.

Test Plan:
- Reset, then pc_in=0, gnt=1, rvalid 1 cycle after grant, rdata=32'h00500093, instr_ready=1 -> pc_advance pulse at grant; instr_valid=1 next cycle with instr=32'h00500093, instr_pc=0; after reset, all outputs 0.
- instr_ready=0, gnt=1 for PCs 0,4,8 -> two grants only (DEPTH=2); imem_req=0 while count+inflight=2; raise ready -> head 0, then 4, in order; issue resumes.
- gnt held 0 for 3 cycles at pc_in=32'h10 -> imem_req high, imem_addr=32'h10 stable, pc_advance=0 until grant.
- Two grants in flight, flush, then the two responses -> both dropped, instr_valid stays 0, no imem_req until the second response, then a fetch of the new pc_in=32'h80.
- Flush in the same cycle as an rvalid with inflight=1 -> response dropped, discard=0, state stays RUN, fetch resumes next cycle.
- With IFETCH_MISALIGN_CHECK_EN and pc_in=32'h6, inflight=0 -> imem_req=0, pc_advance=1, entry instr=32'h00000013, instr_pc=32'h6, instr_fault=1. Without the macro -> imem_addr=32'h4, instr_fault=0.
